// File: rtl/msi001_spi_queue.sv
// rtl/msi001_spi_queue.sv - queued MSB-first SPI write master for the MSi001 tuner
// Defining MSI001_SPI_TXCNT_EN adds the tx_count[15:0] completed-frame counter output.
module msi001_spi_queue #(
  parameter int DATA_W  = 24,
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       spi_msi001_data_out,
  output logic                       spi_msi001_clk_out,
  output logic                       spi_msi001_en_out
`ifdef MSI001_SPI_TXCNT_EN
  ,
  output logic [15:0]                tx_count
`endif
);
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = $clog2(DEPTH + 1);
  localparam int BW   = $clog2(DATA_W);
  localparam int CMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, GAP} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              high_q, high_d;
  logic              data_q, data_d, sclk_q, sclk_d, en_q, en_d, done_q, done_d;
  logic              push, pop;

  assign wr_ready = (level_q != LW'(DEPTH));
  assign push     = wr_valid && wr_ready;
  assign pop      = (state_q == IDLE) && (level_q != '0);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    state_d  = state_q;
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    high_d   = high_q;
    case (state_q)
      IDLE: if (pop) begin
        shreg_d = mem_q[rd_ptr_q];
        bit_d   = BW'(DATA_W - 1);
        cnt_d   = '0;
        state_d = LEAD;
      end
      LEAD: if (cnt_q == CW'(CLK_DIV - 1)) begin
        cnt_d   = '0;
        high_d  = 1'b1;
        state_d = SHIFT;
      end else cnt_d = cnt_q + CW'(1);
      SHIFT: if (cnt_q != CW'(CLK_DIV - 1)) cnt_d = cnt_q + CW'(1);
      else begin
        cnt_d = '0;
        // next bit is staged on the falling edge; the last bit stays put through its low phase
        if (high_q) begin
          high_d = 1'b0;
          if (bit_q != '0) shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        end else if (bit_q == '0) begin
          state_d = GAP;
        end else begin
          high_d = 1'b1;
          bit_d  = bit_q - BW'(1);
        end
      end
      GAP: if (cnt_q == CW'(CS_GAP - 1)) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else cnt_d = cnt_q + CW'(1);
      default: state_d = IDLE;
    endcase
    // pins follow the state one cycle later, which places en fall two edges after acceptance
    en_d   = !((state_q == LEAD) || (state_q == SHIFT));
    sclk_d = (state_q == SHIFT) && high_q;
    data_d = !en_d && shreg_q[DATA_W-1];
    done_d = (state_q == GAP) && (cnt_q == CW'(CS_GAP - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= IDLE;
      shreg_q  <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      high_q   <= 1'b0;
      data_q   <= 1'b0;
      sclk_q   <= 1'b0;
      en_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      high_q   <= high_d;
      data_q   <= data_d;
      sclk_q   <= sclk_d;
      en_q     <= en_d;
      done_q   <= done_d;
    end
  end

  assign fifo_level          = level_q;
  assign busy                = (state_q != IDLE) || (level_q != '0);
  assign frame_done          = done_q;
  assign spi_msi001_data_out = data_q;
  assign spi_msi001_clk_out  = sclk_q;
  assign spi_msi001_en_out   = en_q;

`ifdef MSI001_SPI_TXCNT_EN
  logic [15:0] txc_q, txc_d;

  always_comb begin
    txc_d = txc_q + 16'(done_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) txc_q <= '0;
    else     txc_q <= txc_d;
  end

  assign tx_count = txc_q;
`endif
endmodule
